circle_motion_ctrl: RTL and testbench
=====================================

# circle_motion_ctrl

Frame-synchronous position controller for the circle sprite renderer. It collects gamepad direction and centre buttons between frames and computes one clamped position step per frame. It drives the sprite centre coordinates only at the start of vertical blanking, so the renderer never sees a position change mid-frame. It sits between the gamepad decoder and the circle sprite block.

## Interface
Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- RADIUS, 8, sprite radius; sets the clamp margin
- STEP, 2, pixels moved per frame per axis (1..RADIUS)
- INIT_X, 320, reset/recentre x
- INIT_Y, 240, reset/recentre y

Ports:
- CLK  in  1  pixel clock
- RST  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- btn_up, btn_down, btn_left, btn_right, btn_center  in  1 each  raw gamepad buttons, asynchronous to CLK
- blue_circle_x  out  10  sprite centre x
- blue_circle_y  out  9  sprite centre y
- pos_updated  out  1  one-cycle pulse when new coordinates become visible
- busy  out  1  high while the FSM is not IDLE
- overrun  out  1  sticky; a frame_tick arrived while busy

## Operation
- Each button passes through a 2-flop synchroniser, then a sticky latch. The latch is set by the synchronised level and holds until snapshot.
- FSM states: IDLE, CALC_X, CALC_Y, COMMIT.
  - IDLE + frame_tick: snapshot all latches into the press register, clear the latches, go to CALC_X. A synchronised press in the snapshot cycle sets the fresh latch, so it counts for the next frame and is not lost.
  - CALC_X: compute next_x (11-bit signed). Right only: +STEP. Left only: −STEP. Both or neither: unchanged.
  - CALC_Y: same rule for y in 10-bit signed. Down: +STEP. Up: −STEP.
  - Centre pressed: next_x = INIT_X and next_y = INIT_Y. This overrides all directions.
  - COMMIT: clamp next_x to [RADIUS, SCREEN_W−1−RADIUS] (default [8,631]) and next_y to [RADIUS, SCREEN_H−1−RADIUS] (default [8,471]). Register the outputs, go to IDLE. Edges saturate; there is no wrap-around.
- frame_tick in CALC_X, CALC_Y or COMMIT is ignored and sets overrun. Only RST clears overrun.
- Reset mid-operation: the FSM returns to IDLE, the in-flight step is discarded, and all latches and synchronisers clear.

## Timing
- Reset values:
  - blue_circle_x = INIT_X
  - blue_circle_y = INIT_Y
  - pos_updated = 0
  - busy = 0
  - overrun = 0
  - FSM = IDLE
- frame_tick sampled at edge E0 → CALC_X. E1 → CALC_Y. E2 → COMMIT. At E3 the outputs update and pos_updated = 1 for exactly one cycle.
- Latency is 3 cycles from the tick edge to new coordinates.
- busy is high from E0 to E3. A tick in the cycle after E3 is accepted.
- Button-to-latch latency is 2 cycles (synchroniser). A press must be high at or before edge E0−3 to count in the frame of the E0 tick.
- Outputs hold constant at all times except the E3 update edge.

## Structure
- Shared package sprite_pkg holds:
  - SCREEN_W, SCREEN_H
  - coordinate widths: X_W = 10, Y_W = 9
  - state enum {IDLE, CALC_X, CALC_Y, COMMIT}
  - direction bit indices for the 5-bit press vector
- One sub-module, btn_sync_latch: per-button 2-flop synchroniser plus sticky latch, with a clear input and a snapshot-safe set-over-clear rule. Instantiate it five times.

## Test plan
- Reset test: assert RST mid-CALC_Y → outputs are (320,240), busy = 0, overrun = 0, and the next tick with no buttons keeps (320,240).
- Single step: hold btn_right for 10 cycles, then tick → at E3 blue_circle_x = 322, y = 240, and pos_updated pulses for exactly one cycle.
- Opposite buttons: btn_left and btn_right together, plus btn_down → x unchanged, y = 242.
- Clamp: drive x to 630 via repeated right ticks → the sequence ends 630 → 631 → 631, and y saturates at 8 with up held.
- Centre override: position (100,50), centre and left pressed → (320,240) after the tick.
- Overrun and latch timing:
  - A second tick at E1 is ignored and overrun = 1, sticky.
  - A press that first becomes synchronised in the snapshot cycle is applied on the following frame, not the current one.

Source files
------------

// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sprite_pkg
// Purpose  : Shared definitions for the circle sprite blocks: screen size,
//            coordinate widths, the motion FSM state encoding and the bit
//            positions of each button in the 5-bit press vector.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sprite_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Coordinate widths of the sprite centre outputs.
  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC_X = 2'd1,
    CALC_Y = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // Bit positions inside the press vector.
  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;
  localparam int N_BTN      = 5;

endpackage
`default_nettype wire

// File: rtl/btn_sync_latch.sv
`default_nettype none
// ============================================================================
// Module   : btn_sync_latch
// Purpose  : Brings one raw gamepad button into the CLK domain through a
//            2-flop synchroniser and holds any press in a sticky latch until
//            the frame snapshot clears it.
// Ports    : CLK     in  clock
//            RST     in  asynchronous active-high reset
//            btn     in  raw button, asynchronous to CLK
//            clr     in  snapshot strobe, clears the latch
//            latched out sticky press flag
// Revision : 1.0 - initial release
// ============================================================================
module btn_sync_latch (
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  input  logic clr,
  output logic latched
);

  logic r_sync1;
  logic r_sync2;
  logic r_latch;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_latch <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      // Set wins over clear: a press that is synchronised in the very cycle
      // the latch is snapshotted lands in the fresh latch for the next frame.
      r_latch <= r_sync2 | (r_latch & ~clr);
    end
  end

  assign latched = r_latch;

endmodule
`default_nettype wire

// File: rtl/circle_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : circle_motion_ctrl
// Purpose  : Frame-synchronous position controller for the circle sprite.
//            Collects button presses between frames, and on each frame_tick
//            computes one clamped step, publishing new coordinates 3 cycles
//            after the tick edge so the renderer never sees a mid-frame move.
// Ports    : CLK            in  pixel clock
//            RST            in  asynchronous active-high reset
//            frame_tick     in  one-cycle pulse at start of vertical blanking
//            btn_up/down/left/right/center in raw buttons (async)
//            blue_circle_x  out sprite centre x
//            blue_circle_y  out sprite centre y
//            pos_updated    out one-cycle pulse when new coordinates appear
//            busy           out high while the FSM is not IDLE
//            overrun        out sticky: frame_tick arrived while busy
// Revision : 1.0 - initial release
// ============================================================================
module circle_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int SCREEN_W = sprite_pkg::SCREEN_W,
  parameter int SCREEN_H = sprite_pkg::SCREEN_H,
  parameter int RADIUS   = 8,
  parameter int STEP     = 2,
  parameter int INIT_X   = 320,
  parameter int INIT_Y   = 240
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           frame_tick,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           btn_left,
  input  logic           btn_right,
  input  logic           btn_center,
  output logic [X_W-1:0] blue_circle_x,
  output logic [Y_W-1:0] blue_circle_y,
  output logic           pos_updated,
  output logic           busy,
  output logic           overrun
);

  // Working values carry one extra sign bit so a step below zero or past the
  // right/bottom edge is still representable before the clamp.
  localparam int c_X_MAX_I = SCREEN_W - 1 - RADIUS;
  localparam int c_Y_MAX_I = SCREEN_H - 1 - RADIUS;

  localparam logic signed [X_W:0] c_X_MIN  = RADIUS[X_W:0];
  localparam logic signed [X_W:0] c_X_MAX  = c_X_MAX_I[X_W:0];
  localparam logic signed [X_W:0] c_X_INIT = INIT_X[X_W:0];
  localparam logic signed [X_W:0] c_X_STEP = STEP[X_W:0];

  localparam logic signed [Y_W:0] c_Y_MIN  = RADIUS[Y_W:0];
  localparam logic signed [Y_W:0] c_Y_MAX  = c_Y_MAX_I[Y_W:0];
  localparam logic signed [Y_W:0] c_Y_INIT = INIT_Y[Y_W:0];
  localparam logic signed [Y_W:0] c_Y_STEP = STEP[Y_W:0];

  state_t r_state;
  state_t w_state_nxt;
  logic   w_snap;

  logic [N_BTN-1:0] w_btn_raw;
  logic [N_BTN-1:0] w_latched;
  logic [N_BTN-1:0] r_press;

  logic signed [X_W:0] r_next_x;
  logic signed [Y_W:0] r_next_y;
  logic signed [X_W:0] w_cur_x;
  logic signed [Y_W:0] w_cur_y;
  logic signed [X_W:0] w_calc_x;
  logic signed [Y_W:0] w_calc_y;
  logic [X_W-1:0]      w_clamp_x;
  logic [Y_W-1:0]      w_clamp_y;

  // --------------------------------------------------------------------------
  // Button capture
  // --------------------------------------------------------------------------
  always_comb begin
    w_btn_raw             = '0;
    w_btn_raw[BTN_UP]     = btn_up;
    w_btn_raw[BTN_DOWN]   = btn_down;
    w_btn_raw[BTN_LEFT]   = btn_left;
    w_btn_raw[BTN_RIGHT]  = btn_right;
    w_btn_raw[BTN_CENTER] = btn_center;
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    btn_sync_latch u_btn (
      .CLK     (CLK),
      .RST     (RST),
      .btn     (w_btn_raw[gi]),
      .clr     (w_snap),
      .latched (w_latched[gi])
    );
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_snap      = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_tick) begin
          w_snap      = 1'b1;
          w_state_nxt = CALC_X;
        end
      end
      CALC_X:  w_state_nxt = CALC_Y;
      CALC_Y:  w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

  // --------------------------------------------------------------------------
  // Step arithmetic; centre overrides any direction, opposing pairs cancel.
  // --------------------------------------------------------------------------
  assign w_cur_x = {1'b0, blue_circle_x};
  assign w_cur_y = {1'b0, blue_circle_y};

  always_comb begin
    w_calc_x = w_cur_x;
    if (r_press[BTN_CENTER]) begin
      w_calc_x = c_X_INIT;
    end else if (r_press[BTN_RIGHT] && !r_press[BTN_LEFT]) begin
      w_calc_x = w_cur_x + c_X_STEP;
    end else if (r_press[BTN_LEFT] && !r_press[BTN_RIGHT]) begin
      w_calc_x = w_cur_x - c_X_STEP;
    end
  end

  always_comb begin
    w_calc_y = w_cur_y;
    if (r_press[BTN_CENTER]) begin
      w_calc_y = c_Y_INIT;
    end else if (r_press[BTN_DOWN] && !r_press[BTN_UP]) begin
      w_calc_y = w_cur_y + c_Y_STEP;
    end else if (r_press[BTN_UP] && !r_press[BTN_DOWN]) begin
      w_calc_y = w_cur_y - c_Y_STEP;
    end
  end

  // Saturating clamp keeps the whole circle on screen.
  always_comb begin
    if (r_next_x < c_X_MIN) begin
      w_clamp_x = c_X_MIN[X_W-1:0];
    end else if (r_next_x > c_X_MAX) begin
      w_clamp_x = c_X_MAX[X_W-1:0];
    end else begin
      w_clamp_x = r_next_x[X_W-1:0];
    end
  end

  always_comb begin
    if (r_next_y < c_Y_MIN) begin
      w_clamp_y = c_Y_MIN[Y_W-1:0];
    end else if (r_next_y > c_Y_MAX) begin
      w_clamp_y = c_Y_MAX[Y_W-1:0];
    end else begin
      w_clamp_y = r_next_y[Y_W-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers and outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_press       <= '0;
      r_next_x      <= c_X_INIT;
      r_next_y      <= c_Y_INIT;
      blue_circle_x <= c_X_INIT[X_W-1:0];
      blue_circle_y <= c_Y_INIT[Y_W-1:0];
      pos_updated   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      pos_updated <= 1'b0;
      if (frame_tick && (r_state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (frame_tick) begin
            r_press <= w_latched;
          end
        end
        CALC_X: r_next_x <= w_calc_x;
        CALC_Y: r_next_y <= w_calc_y;
        COMMIT: begin
          blue_circle_x <= w_clamp_x;
          blue_circle_y <= w_clamp_y;
          pos_updated   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_circle_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_circle_motion_ctrl
// Purpose  : Directed self-checking bench for circle_motion_ctrl.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_circle_motion_ctrl;

  localparam logic [4:0] c_B_UP    = 5'b00001;
  localparam logic [4:0] c_B_DOWN  = 5'b00010;
  localparam logic [4:0] c_B_LEFT  = 5'b00100;
  localparam logic [4:0] c_B_RIGHT = 5'b01000;
  localparam logic [4:0] c_B_CTR   = 5'b10000;

  logic       CLK;
  logic       RST;
  logic       frame_tick;
  logic       btn_up, btn_down, btn_left, btn_right, btn_center;
  logic [9:0] blue_circle_x;
  logic [8:0] blue_circle_y;
  logic       pos_updated;
  logic       busy;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  circle_motion_ctrl dut (
    .CLK           (CLK),
    .RST           (RST),
    .frame_tick    (frame_tick),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_center    (btn_center),
    .blue_circle_x (blue_circle_x),
    .blue_circle_y (blue_circle_y),
    .pos_updated   (pos_updated),
    .busy          (busy),
    .overrun       (overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_btns(input logic [4:0] m);
    btn_up     = m[0];
    btn_down   = m[1];
    btn_left   = m[2];
    btn_right  = m[3];
    btn_center = m[4];
  endtask

  // Press, release, let the synchronisers drain, then tick. Returns #1 after E3.
  task automatic run_frame(input logic [4:0] m);
    set_btns(m);
    step(10);
    set_btns(5'b0);
    step(3);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(3);
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    step(2);
    RST = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    pulse_reset();
    n_checks++; if (blue_circle_x !== 10'd320) begin n_fail++; $display("FAIL reset_x: got %0d expected 320", blue_circle_x); end
    n_checks++; if (blue_circle_y !== 9'd240) begin n_fail++; $display("FAIL reset_y: got %0d expected 240", blue_circle_y); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (pos_updated !== 1'b0) begin n_fail++; $display("FAIL reset_pu: got %b expected 0", pos_updated); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", overrun); end
    // Start a right step and kill it with reset while in CALC_Y.
    set_btns(c_B_RIGHT);
    step(10);
    set_btns(5'b0);
    step(3);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midcalc_busy: got %b expected 1", busy); end
    RST = 1'b1;
    #2;
    n_checks++; if (blue_circle_x !== 10'd320) begin n_fail++; $display("FAIL midrst_x: got %0d expected 320", blue_circle_x); end
    n_checks++; if (blue_circle_y !== 9'd240) begin n_fail++; $display("FAIL midrst_y: got %0d expected 240", blue_circle_y); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_ovr: got %b expected 0", overrun); end
    step(1);
    RST = 1'b0;
    step(1);
    run_frame(5'b0);
    n_checks++; if (blue_circle_x !== 10'd320) begin n_fail++; $display("FAIL postrst_x: got %0d expected 320", blue_circle_x); end
    n_checks++; if (blue_circle_y !== 9'd240) begin n_fail++; $display("FAIL postrst_y: got %0d expected 240", blue_circle_y); end
  endtask

  task automatic test_single_step();
    run_frame(c_B_RIGHT);
    n_checks++; if (blue_circle_x !== 10'd322) begin n_fail++; $display("FAIL step_x: got %0d expected 322", blue_circle_x); end
    n_checks++; if (blue_circle_y !== 9'd240) begin n_fail++; $display("FAIL step_y: got %0d expected 240", blue_circle_y); end
    n_checks++; if (pos_updated !== 1'b1) begin n_fail++; $display("FAIL step_pu_hi: got %b expected 1", pos_updated); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL step_busy_e3: got %b expected 0", busy); end
    step(1);
    n_checks++; if (pos_updated !== 1'b0) begin n_fail++; $display("FAIL step_pu_lo: got %b expected 0", pos_updated); end
    n_checks++; if (blue_circle_x !== 10'd322) begin n_fail++; $display("FAIL step_hold_x: got %0d expected 322", blue_circle_x); end
  endtask

  task automatic test_opposite();
    run_frame(c_B_LEFT | c_B_RIGHT | c_B_DOWN);
    n_checks++; if (blue_circle_x !== 10'd322) begin n_fail++; $display("FAIL opp_x: got %0d expected 322", blue_circle_x); end
    n_checks++; if (blue_circle_y !== 9'd242) begin n_fail++; $display("FAIL opp_y: got %0d expected 242", blue_circle_y); end
  endtask

  // Press first synchronised in the snapshot cycle goes to the next frame;
  // the second frame is ticked in the cycle right after E3.
  task automatic test_back_to_back();
    step(2);
    btn_right = 1'b1;
    step(2);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    btn_right = 1'b0;
    step(3);
    n_checks++; if (blue_circle_x !== 10'd322) begin n_fail++; $display("FAIL late_press_x: got %0d expected 322", blue_circle_x); end
    n_checks++; if (pos_updated !== 1'b1) begin n_fail++; $display("FAIL late_press_pu: got %b expected 1", pos_updated); end
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    step(3);
    n_checks++; if (blue_circle_x !== 10'd324) begin n_fail++; $display("FAIL b2b_x: got %0d expected 324", blue_circle_x); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_ovr: got %b expected 0", overrun); end
  endtask

  task automatic test_overrun();
    step(2);
    frame_tick = 1'b1;
    step(1);
    step(1);
    frame_tick = 1'b0;
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    n_checks++; if (blue_circle_x !== 10'd324) begin n_fail++; $display("FAIL ovr_hold_x: got %0d expected 324", blue_circle_x); end
    step(2);
    n_checks++; if (pos_updated !== 1'b1) begin n_fail++; $display("FAIL ovr_pu: got %b expected 1", pos_updated); end
    step(1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovr_ignored_busy: got %b expected 0", busy); end
    step(4);
    n_checks++; if (pos_updated !== 1'b0) begin n_fail++; $display("FAIL ovr_no_extra_pu: got %b expected 0", pos_updated); end
    run_frame(5'b0);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    n_checks++; if (blue_circle_x !== 10'd324) begin n_fail++; $display("FAIL ovr_pos_x: got %0d expected 324", blue_circle_x); end
    n_checks++; if (blue_circle_y !== 9'd242) begin n_fail++; $display("FAIL ovr_pos_y: got %0d expected 242", blue_circle_y); end
  endtask

  // From (324,242): 153 right+up frames give x=630, y saturated at 8.
  task automatic test_clamp();
    for (int i = 0; i < 153; i++) run_frame(c_B_RIGHT | c_B_UP);
    n_checks++; if (blue_circle_x !== 10'd630) begin n_fail++; $display("FAIL clamp_x630: got %0d expected 630", blue_circle_x); end
    n_checks++; if (blue_circle_y !== 9'd8) begin n_fail++; $display("FAIL clamp_y8: got %0d expected 8", blue_circle_y); end
    run_frame(c_B_RIGHT | c_B_UP);
    n_checks++; if (blue_circle_x !== 10'd631) begin n_fail++; $display("FAIL clamp_x631: got %0d expected 631", blue_circle_x); end
    run_frame(c_B_RIGHT | c_B_UP);
    n_checks++; if (blue_circle_x !== 10'd631) begin n_fail++; $display("FAIL clamp_x_sat: got %0d expected 631", blue_circle_x); end
    n_checks++; if (blue_circle_y !== 9'd8) begin n_fail++; $display("FAIL clamp_y_sat: got %0d expected 8", blue_circle_y); end
  endtask

  task automatic test_center();
    pulse_reset();
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ctr_rst_ovr: got %b expected 0", overrun); end
    for (int i = 0; i < 95; i++) run_frame(c_B_LEFT | c_B_UP);
    for (int i = 0; i < 15; i++) run_frame(c_B_LEFT);
    n_checks++; if (blue_circle_x !== 10'd100) begin n_fail++; $display("FAIL ctr_pre_x: got %0d expected 100", blue_circle_x); end
    n_checks++; if (blue_circle_y !== 9'd50) begin n_fail++; $display("FAIL ctr_pre_y: got %0d expected 50", blue_circle_y); end
    run_frame(c_B_CTR | c_B_LEFT);
    n_checks++; if (blue_circle_x !== 10'd320) begin n_fail++; $display("FAIL ctr_x: got %0d expected 320", blue_circle_x); end
    n_checks++; if (blue_circle_y !== 9'd240) begin n_fail++; $display("FAIL ctr_y: got %0d expected 240", blue_circle_y); end
  endtask

  initial begin
    RST        = 1'b1;
    frame_tick = 1'b0;
    set_btns(5'b0);
    step(2);
    test_reset();
    test_single_step();
    test_opposite();
    test_back_to_back();
    test_overrun();
    test_clamp();
    test_center();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
